string_stream_rom: RTL and testbench



---
 rtl/string_stream_rom_pkg.sv | 60 ++++++
 rtl/string_stream_rom_rom_sync.sv | 41 ++++
 rtl/string_stream_rom.sv | 172 +++++++++++++++++
 tb/tb_string_stream_rom.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/string_stream_rom_pkg.sv
// Shared definitions for the string streaming ROM: character codes, default
// geometry, the ROM image and the controller state encoding.
package string_pkg;

    localparam int STRING_NUM_DEF = 13;
    localparam int MAX_CHAR_DEF   = 11;
    localparam int CHAR_WIDTH_DEF = 5;
    localparam int ROW_W          = MAX_CHAR_DEF * CHAR_WIDTH_DEF;

    localparam logic [4:0] CHAR_A = 5'd0,  CHAR_B = 5'd1,  CHAR_C = 5'd2,  CHAR_D = 5'd3;
    localparam logic [4:0] CHAR_E = 5'd4,  CHAR_F = 5'd5,  CHAR_G = 5'd6,  CHAR_H = 5'd7;
    localparam logic [4:0] CHAR_I = 5'd8,  CHAR_J = 5'd9,  CHAR_K = 5'd10, CHAR_L = 5'd11;
    localparam logic [4:0] CHAR_M = 5'd12, CHAR_N = 5'd13, CHAR_O = 5'd14, CHAR_P = 5'd15;
    localparam logic [4:0] CHAR_Q = 5'd16, CHAR_R = 5'd17, CHAR_S = 5'd18, CHAR_T = 5'd19;
    localparam logic [4:0] CHAR_U = 5'd20, CHAR_V = 5'd21, CHAR_W = 5'd22, CHAR_X = 5'd23;
    localparam logic [4:0] CHAR_Y = 5'd24, CHAR_Z = 5'd25;
    localparam logic [4:0] CHAR_COLON = 5'd26;
    localparam logic [4:0] CHAR_DASH  = 5'd27;
    localparam logic [4:0] CHAR_SPACE = 5'd28;

    // Leftmost column is the most significant character of each row.
    localparam logic [ROW_W-1:0] ROW_00 = {CHAR_G, CHAR_A, CHAR_M, CHAR_E, CHAR_SPACE, CHAR_T,
                                           CHAR_I, CHAR_M, CHAR_E, CHAR_COLON, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_01 = {CHAR_S, CHAR_C, CHAR_O, CHAR_R, CHAR_E, CHAR_COLON,
                                           CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_02 = {CHAR_L, CHAR_E, CHAR_V, CHAR_E, CHAR_L, CHAR_COLON,
                                           CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_03 = {CHAR_P, CHAR_L, CHAR_A, CHAR_Y, CHAR_E, CHAR_R,
                                           CHAR_SPACE, CHAR_O, CHAR_N, CHAR_E, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_04 = {CHAR_P, CHAR_L, CHAR_A, CHAR_Y, CHAR_E, CHAR_R,
                                           CHAR_SPACE, CHAR_T, CHAR_W, CHAR_O, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_05 = {CHAR_G, CHAR_A, CHAR_M, CHAR_E, CHAR_SPACE, CHAR_O,
                                           CHAR_V, CHAR_E, CHAR_R, CHAR_SPACE, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_06 = {CHAR_P, CHAR_A, CHAR_U, CHAR_S, CHAR_E, CHAR_D,
                                           CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_07 = {CHAR_DASH, CHAR_DASH, CHAR_DASH, CHAR_DASH, CHAR_DASH, CHAR_DASH,
                                           CHAR_DASH, CHAR_DASH, CHAR_DASH, CHAR_DASH, CHAR_DASH};
    localparam logic [ROW_W-1:0] ROW_08 = {CHAR_P, CHAR_R, CHAR_E, CHAR_S, CHAR_S, CHAR_SPACE,
                                           CHAR_S, CHAR_T, CHAR_A, CHAR_R, CHAR_T};
    localparam logic [ROW_W-1:0] ROW_09 = {CHAR_H, CHAR_I, CHAR_G, CHAR_H, CHAR_SPACE, CHAR_S,
                                           CHAR_C, CHAR_O, CHAR_R, CHAR_E, CHAR_COLON};
    localparam logic [ROW_W-1:0] ROW_10 = {CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE,
                                           CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_11 = {CHAR_Y, CHAR_O, CHAR_U, CHAR_SPACE, CHAR_W, CHAR_I,
                                           CHAR_N, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE, CHAR_SPACE};
    localparam logic [ROW_W-1:0] ROW_12 = {CHAR_I, CHAR_N, CHAR_S, CHAR_T, CHAR_R, CHAR_U,
                                           CHAR_C, CHAR_T, CHAR_I, CHAR_O, CHAR_N};

    localparam logic [STRING_NUM_DEF*ROW_W-1:0] ROM_IMAGE = {
        ROW_12, ROW_11, ROW_10, ROW_09, ROW_08, ROW_07, ROW_06,
        ROW_05, ROW_04, ROW_03, ROW_02, ROW_01, ROW_00
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_e;

endpackage

// File: rtl/string_stream_rom_rom_sync.sv
// Registered-read string ROM; one full row per access so the read maps to block RAM.
module string_rom_sync
    import string_pkg::*;
#(
    parameter int STRING_NUM = STRING_NUM_DEF,
    parameter int MAX_CHAR   = MAX_CHAR_DEF,
    parameter int CHAR_WIDTH = CHAR_WIDTH_DEF,
    parameter int SEL_W      = $clog2(STRING_NUM),
    parameter logic [STRING_NUM*MAX_CHAR*CHAR_WIDTH-1:0] IMAGE = ROM_IMAGE
) (
    input  logic                           clk,
    input  logic [SEL_W-1:0]               addr,
    output logic [MAX_CHAR*CHAR_WIDTH-1:0] row_out
);

    localparam int ROW_BITS = MAX_CHAR * CHAR_WIDTH;

    logic [ROW_BITS-1:0] rows [STRING_NUM];
    logic [ROW_BITS-1:0] row_d;

    (* rom_style = "block" *) logic [ROW_BITS-1:0] row_q;

    for (genvar k = 0; k < STRING_NUM; k++) begin : g_rows
        assign rows[k] = IMAGE[k*ROW_BITS +: ROW_BITS];
    end

    // Unpopulated addresses read as zero rather than indexing past the image.
    always_comb begin
        row_d = '0;
        if (int'(addr) < STRING_NUM) begin
            row_d = rows[addr];
        end
    end

    always_ff @(posedge clk) begin
        row_q <= row_d;
    end

    assign row_out = row_q;

endmodule

// File: rtl/string_stream_rom.sv
// Streams one stored string a character per beat over valid/ready, with optional
// trailing-space trimming and a repeat count.
module string_stream_rom
    import string_pkg::*;
#(
    parameter int STRING_NUM = STRING_NUM_DEF,
    parameter int MAX_CHAR   = MAX_CHAR_DEF,
    parameter int CHAR_WIDTH = CHAR_WIDTH_DEF,
    parameter int SEL_W      = $clog2(STRING_NUM),
    parameter int IDX_W      = $clog2(MAX_CHAR),
    parameter int REP_W      = 2,
    parameter logic [STRING_NUM*MAX_CHAR*CHAR_WIDTH-1:0] IMAGE = ROM_IMAGE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_W-1:0]      req_sel,
    input  logic                  req_trim,
    input  logic [REP_W-1:0]      req_rep,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHAR_WIDTH-1:0] out_char,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err
);

    localparam int ROW_BITS = MAX_CHAR * CHAR_WIDTH;
    localparam logic [SEL_W:0]      NUM_C   = (SEL_W+1)'(STRING_NUM);
    localparam logic [IDX_W:0]      LEN_MAX = (IDX_W+1)'(MAX_CHAR);
    localparam logic [IDX_W:0]      LEN_ONE = (IDX_W+1)'(1);
    localparam logic [CHAR_WIDTH-1:0] SPACE_C = CHAR_WIDTH'(CHAR_SPACE);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              trim_q, trim_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [IDX_W:0]    col_q, col_d;
    logic [IDX_W:0]    len_q, len_d;
    logic              err_q, err_d;

    logic [SEL_W-1:0]    rom_addr;
    logic [ROW_BITS-1:0] row;
    logic [IDX_W:0]      last_nonspace;
    logic [IDX_W:0]      fetch_len;
    logic [IDX_W:0]      last_col;
    logic [CHAR_WIDTH-1:0] cur_char;
    logic                sel_ok;
    logic                at_last_col;

    // Addressing straight from req_sel while idle lets the row land during FETCH;
    // afterwards the held select keeps the ROM output stable as the line buffer.
    assign rom_addr = (state_q == IDLE) ? req_sel : sel_q;

    string_rom_sync #(
        .STRING_NUM (STRING_NUM),
        .MAX_CHAR   (MAX_CHAR),
        .CHAR_WIDTH (CHAR_WIDTH),
        .SEL_W      (SEL_W),
        .IMAGE      (IMAGE)
    ) u_rom (
        .clk     (clk),
        .addr    (rom_addr),
        .row_out (row)
    );

    always_comb begin
        last_nonspace = '0;
        for (int i = 0; i < MAX_CHAR; i++) begin
            if (row[(MAX_CHAR-1-i)*CHAR_WIDTH +: CHAR_WIDTH] != SPACE_C) begin
                last_nonspace = (IDX_W+1)'(i + 1);
            end
        end
        if (!trim_q) begin
            fetch_len = LEN_MAX;
        end else if (last_nonspace == '0) begin
            fetch_len = LEN_ONE;
        end else begin
            fetch_len = last_nonspace;
        end
    end

    always_comb begin
        cur_char = '0;
        for (int i = 0; i < MAX_CHAR; i++) begin
            if (col_q == (IDX_W+1)'(i)) begin
                cur_char = row[(MAX_CHAR-1-i)*CHAR_WIDTH +: CHAR_WIDTH];
            end
        end
    end

    assign sel_ok      = {1'b0, req_sel} < NUM_C;
    assign last_col    = len_q - LEN_ONE;
    assign at_last_col = (col_q == last_col);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        trim_d  = trim_q;
        rep_d   = rep_q;
        col_d   = col_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (sel_ok) begin
                        sel_d   = req_sel;
                        trim_d  = req_trim;
                        rep_d   = req_rep;
                        col_d   = '0;
                        state_d = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                len_d   = fetch_len;
                col_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    if (at_last_col) begin
                        col_d = '0;
                        if (rep_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            rep_d = rep_q - REP_W'(1);
                        end
                    end else begin
                        col_d = col_q + LEN_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            trim_q  <= 1'b0;
            rep_q   <= '0;
            col_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            trim_q  <= trim_d;
            rep_q   <= rep_d;
            col_q   <= col_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from registered state so an async reset clears them at once.
    assign out_valid = (state_q == STREAM);
    assign out_char  = out_valid ? cur_char : '0;
    assign out_idx   = out_valid ? col_q[IDX_W-1:0] : '0;
    assign out_last  = out_valid && at_last_col && (rep_q == '0);
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_string_stream_rom.sv
// Self-checking bench: directed and randomized requests checked against a
// text-level model of the stored strings.
module tb_string_stream_rom;

    localparam int STRING_NUM = 13;
    localparam int MAX_CHAR   = 11;
    localparam int CHAR_WIDTH = 5;
    localparam int SEL_W      = 4;
    localparam int IDX_W      = 4;
    localparam int REP_W      = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [SEL_W-1:0]      req_sel = '0;
    logic                  req_trim = 1'b0;
    logic [REP_W-1:0]      req_rep = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [CHAR_WIDTH-1:0] out_char;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_last;
    logic                  busy;
    logic                  err;

    int checks = 0;
    int errors = 0;

    string strs [STRING_NUM] = '{
        "GAME TIME: ", "SCORE:     ", "LEVEL:     ", "PLAYER ONE ",
        "PLAYER TWO ", "GAME OVER  ", "PAUSED     ", "-----------",
        "PRESS START", "HIGH SCORE:", "           ", "YOU WIN    ",
        "INSTRUCTION"
    };

    string_stream_rom dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_trim  (req_trim),
        .req_rep   (req_rep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int code_of(input byte c);
        if (c == " ") return 28;
        if (c == ":") return 26;
        if (c == "-") return 27;
        return int'(c) - int'("A");
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to completion against the text model.
    task automatic do_stream(input int sel, input bit trim, input int rep, input bit rand_ready);
        int exp_char[$];
        int exp_idx[$];
        bit exp_last[$];
        int len;
        int n;
        int beat;
        int cyc;
        bit first;
        string s;
        s = strs[sel];
        len = MAX_CHAR;
        if (trim) begin
            len = 0;
            for (int i = 0; i < MAX_CHAR; i++) if (s[i] != " ") len = i + 1;
            if (len == 0) len = 1;
        end
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < len; i++) begin
                exp_char.push_back(code_of(s[i]));
                exp_idx.push_back(i);
                exp_last.push_back((r == rep) && (i == len - 1));
            end
        end
        n = exp_char.size();

        chk("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = SEL_W'(sel);
        req_trim  = trim;
        req_rep   = REP_W'(rep);
        tick();
        req_valid = 1'b0;
        chk("fetch_busy", {30'd0, busy, out_valid}, {30'd0, 1'b1, 1'b0});
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

        beat = 0;
        cyc = 0;
        first = 1'b1;
        while (beat < n) begin
            tick();
            cyc++;
            if (cyc > 400) begin
                chk("stream_timeout", 32'(beat), 32'(n));
                break;
            end
            if (first) begin
                chk("first_beat_latency", 32'(out_valid), 32'd1);
                first = 1'b0;
            end
            if (out_valid) begin
                chk($sformatf("beat%0d_sel%0d", beat, sel),
                    {19'd0, out_char, out_idx, 3'd0, out_last},
                    {19'd0, CHAR_WIDTH'(exp_char[beat]), IDX_W'(exp_idx[beat]), 3'd0, exp_last[beat]});
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) beat++;
            end else begin
                chk("valid_gap", 32'(out_valid), 32'd1);
                out_ready = 1'b1;
            end
        end
        tick();
        chk("done_idle", {29'd0, out_valid, req_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
        out_ready = 1'b1;
    endtask

    task automatic do_bad_sel(input int sel);
        req_valid = 1'b1;
        req_sel   = SEL_W'(sel);
        tick();
        req_valid = 1'b0;
        chk("err_pulse", {29'd0, err, busy, out_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        tick();
        chk("err_clear", {29'd0, err, busy, out_valid}, {29'd0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        int cyc;
        #2;
        chk("reset_outputs", {19'd0, req_ready, out_valid, out_char, out_idx, out_last, busy, err},
                             {19'd0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        tick();

        do_stream(0, 1'b0, 0, 1'b0);
        do_stream(0, 1'b1, 0, 1'b0);
        do_stream(7, 1'b1, 2, 1'b0);
        do_stream(12, 1'b0, 0, 1'b1);
        do_stream(10, 1'b1, 1, 1'b0);
        do_stream(10, 1'b0, 0, 1'b0);
        do_bad_sel(13);
        do_bad_sel(15);

        for (int k = 0; k < 8; k++) begin
            do_stream(int'($urandom_range(0, STRING_NUM - 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stream.
        req_valid = 1'b1;
        req_sel   = 4'd3;
        req_trim  = 1'b0;
        req_rep   = 2'd0;
        out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        cyc = 0;
        while (!(out_valid && out_idx == 4'd5) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("reached_beat5", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset", {29'd0, out_valid, busy, out_last}, {29'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_stream(3, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
